// File: rtl/rock_generator_if.sv
// Link between the rocking controller and the swing generator: amplitude/frequency
// codes in, swing position, status flags and actuator PWM out.
interface rock_generator_if;
  logic        [3:0] A;
  logic        [3:0] F;
  logic signed [7:0] pos;
  logic              dir;
  logic              center;
  logic              active;
  logic              pwm_out;

  modport master (
    output A, F,
    input  pos, dir, center, active, pwm_out
  );

  modport slave (
    input  A, F,
    output pos, dir, center, active, pwm_out
  );
endinterface

// File: rtl/rock_generator.sv
// Triangle swing generator for the cradle actuator: amplitude/frequency codes are
// re-latched only at centre crossings, and the position drives a registered PWM.
module rock_generator #(
  parameter int TICK_DIV   = 50000,
  parameter int PEAK_SCALE = 8
) (
  input  logic           clk,
  input  logic           reset,
  rock_generator_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SWING_UP,
    SWING_DOWN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic               w_tick;
  logic [3:0]         r_a_l;
  logic [3:0]         r_f_l;
  logic [3:0]         w_a_nxt;
  logic [3:0]         w_f_nxt;
  logic signed [7:0]  r_pos;
  logic signed [7:0]  w_pos_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic               r_center;
  logic               w_center_nxt;
  logic [7:0]         r_pwm_cnt;
  logic               r_pwm;
  logic [7:0]         w_duty;
  logic signed [9:0]  w_pos_ext;
  logic signed [9:0]  w_f_ext;
  logic signed [9:0]  w_nxt;
  logic signed [9:0]  w_use_peak;
  logic               w_cross;

  // Peak for an amplitude code, saturated so the position never leaves +/-120.
  function automatic logic signed [9:0] peak_of(input logic [3:0] a);
    logic [15:0] p;
    p = 16'(a) * 16'(PEAK_SCALE);
    return (p > 16'd120) ? 10'sd120 : 10'(p);
  endfunction

  // pos + 128 as an unsigned 8-bit duty threshold.
  function automatic logic [7:0] duty_of(input logic signed [7:0] p);
    return {~p[7], p[6:0]};
  endfunction

  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
  assign w_pos_ext = {{2{r_pos[7]}}, r_pos};
  assign w_f_ext   = {6'b0, r_f_l};
  assign w_nxt     = (r_state == SWING_DOWN) ? (w_pos_ext - w_f_ext) : (w_pos_ext + w_f_ext);
  assign w_cross   = (r_pos != 8'sd0) && ((w_nxt == 10'sd0) || (w_nxt[9] != r_pos[7]));
  assign w_duty    = duty_of(r_pos);

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_dir_nxt    = r_dir;
    w_center_nxt = 1'b0;
    w_a_nxt      = r_a_l;
    w_f_nxt      = r_f_l;
    w_use_peak   = peak_of(r_a_l);
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_a_nxt   = bus.A;
          w_f_nxt   = bus.F;
          w_pos_nxt = 8'sd0;
          if ((bus.A != 4'd0) && (bus.F != 4'd0)) begin
            w_state_nxt = SWING_UP;
            w_dir_nxt   = 1'b1;
          end
        end
        default: begin
          // A centre crossing is the only point where new codes are accepted.
          if (w_cross) begin
            w_center_nxt = 1'b1;
            w_a_nxt      = bus.A;
            w_f_nxt      = bus.F;
            w_use_peak   = peak_of(bus.A);
          end
          if (w_cross && ((bus.A == 4'd0) || (bus.F == 4'd0))) begin
            w_pos_nxt   = 8'sd0;
            w_state_nxt = IDLE;
            w_dir_nxt   = 1'b1;
          end else if ((r_state == SWING_UP) && (w_nxt >= w_use_peak)) begin
            w_pos_nxt   = 8'(w_use_peak);
            w_state_nxt = SWING_DOWN;
            w_dir_nxt   = 1'b0;
          end else if ((r_state == SWING_DOWN) && (w_nxt <= -w_use_peak)) begin
            w_pos_nxt   = 8'(-w_use_peak);
            w_state_nxt = SWING_UP;
            w_dir_nxt   = 1'b1;
          end else begin
            w_pos_nxt = 8'(w_nxt);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_a_l     <= 4'd0;
      r_f_l     <= 4'd0;
      r_pos     <= 8'sd0;
      r_dir     <= 1'b1;
      r_center  <= 1'b0;
      r_pwm_cnt <= 8'd0;
      r_pwm     <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : (r_presc + PW'(1));
      r_state   <= w_state_nxt;
      r_a_l     <= w_a_nxt;
      r_f_l     <= w_f_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_center  <= w_center_nxt;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm     <= (r_pwm_cnt < w_duty);
    end
  end

  assign bus.pos     = r_pos;
  assign bus.dir     = r_dir;
  assign bus.center  = r_center;
  assign bus.active  = (r_state != IDLE);
  assign bus.pwm_out = r_pwm;

endmodule

// File: tb/tb_rock_generator.sv
// Directed bench for rock_generator: swing shape, deferred updates, clamping,
// stop, mid-swing reset and PWM duty.
module tb_rock_generator;

  logic clk = 1'b0;
  logic reset;
  logic reset_p;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rock_generator_if bus ();
  rock_generator_if bus_p ();

  rock_generator #(.TICK_DIV(2), .PEAK_SCALE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rock_generator #(.TICK_DIV(1000), .PEAK_SCALE(8)) dut_p (
    .clk   (clk),
    .reset (reset_p),
    .bus   (bus_p)
  );

  localparam int BP [18] = '{0, 4, 8, 12, 16, 12, 8, 4, 0, -4, -8, -12, -16, -12, -8, -4, 0, 4};
  localparam bit BD [18] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  localparam bit BC [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  localparam int DP [10] = '{8, 4, 0, -4, -8, -4, 0, 4, 8, 4};
  localparam bit DD [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  localparam bit DC [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

  localparam int CP [6] = '{0, 8, -7, -8, 7, 8};
  localparam bit CD [6] = '{1, 0, 0, 1, 1, 0};
  localparam bit CC [6] = '{0, 0, 1, 0, 1, 0};

  task automatic do_reset(input logic [3:0] a, input logic [3:0] f);
    @(negedge clk);
    reset = 1'b1;
    bus.A = a;
    bus.F = f;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    reset_p = 1'b1;
    bus.A   = 4'd5;
    bus.F   = 4'd5;
    repeat (3) @(negedge clk);
    total++; if (bus.pos !== 8'sd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", $signed(bus.pos)); end
    total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", bus.dir); end
    total++; if (bus.center !== 1'b0) begin bad++; $display("FAIL reset_center got=%b want=0", bus.center); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.active); end
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", bus.pwm_out); end
    total++; if (bus_p.pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm_p got=%b want=0", bus_p.pwm_out); end
  endtask

  task automatic test_basic_swing();
    do_reset(4'd2, 4'd4);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      total++; if (bus.center !== 1'b0) begin bad++; $display("FAIL basic_center_offtick[%0d] got=%b want=0", i, bus.center); end
      @(negedge clk);
      total++; if (bus.pos !== 8'(BP[i])) begin bad++; $display("FAIL basic_pos[%0d] got=%0d want=%0d", i, $signed(bus.pos), BP[i]); end
      total++; if (bus.dir !== BD[i]) begin bad++; $display("FAIL basic_dir[%0d] got=%b want=%b", i, bus.dir, BD[i]); end
      total++; if (bus.center !== BC[i]) begin bad++; $display("FAIL basic_center[%0d] got=%b want=%b", i, bus.center, BC[i]); end
      total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL basic_active[%0d] got=%b want=1", i, bus.active); end
    end
  endtask

  task automatic test_deferred_update();
    do_reset(4'd2, 4'd4);
    repeat (6) tick();
    total++; if (bus.pos !== 8'sd12) begin bad++; $display("FAIL defer_start got=%0d want=12", $signed(bus.pos)); end
    bus.A = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.pos !== 8'(DP[i])) begin bad++; $display("FAIL defer_pos[%0d] got=%0d want=%0d", i, $signed(bus.pos), DP[i]); end
      total++; if (bus.dir !== DD[i]) begin bad++; $display("FAIL defer_dir[%0d] got=%b want=%b", i, bus.dir, DD[i]); end
      total++; if (bus.center !== DC[i]) begin bad++; $display("FAIL defer_center[%0d] got=%b want=%b", i, bus.center, DC[i]); end
    end
  endtask

  task automatic test_clamp();
    do_reset(4'd1, 4'd15);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (bus.pos !== 8'(CP[i])) begin bad++; $display("FAIL clamp_pos[%0d] got=%0d want=%0d", i, $signed(bus.pos), CP[i]); end
      total++; if (bus.dir !== CD[i]) begin bad++; $display("FAIL clamp_dir[%0d] got=%b want=%b", i, bus.dir, CD[i]); end
      total++; if (bus.center !== CC[i]) begin bad++; $display("FAIL clamp_center[%0d] got=%b want=%b", i, bus.center, CC[i]); end
    end
  endtask

  task automatic test_stop();
    int exp_pos;
    do_reset(4'd3, 4'd2);
    repeat (8) tick();
    total++; if (bus.pos !== 8'sd14) begin bad++; $display("FAIL stop_start got=%0d want=14", $signed(bus.pos)); end
    bus.F = 4'd0;
    for (int j = 1; j <= 17; j++) begin
      tick();
      exp_pos = (j <= 5) ? (14 + 2 * j) : (24 - 2 * (j - 5));
      total++; if (bus.pos !== 8'(exp_pos)) begin bad++; $display("FAIL stop_pos[%0d] got=%0d want=%0d", j, $signed(bus.pos), exp_pos); end
      total++; if (bus.active !== (j < 17)) begin bad++; $display("FAIL stop_active[%0d] got=%b want=%b", j, bus.active, (j < 17)); end
      total++; if (bus.center !== (j == 17)) begin bad++; $display("FAIL stop_center[%0d] got=%b want=%b", j, bus.center, (j == 17)); end
    end
    total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL stop_dir got=%b want=1", bus.dir); end
    for (int j = 0; j < 3; j++) begin
      tick();
      total++; if (bus.pos !== 8'sd0) begin bad++; $display("FAIL stop_hold_pos[%0d] got=%0d want=0", j, $signed(bus.pos)); end
      total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL stop_hold_active[%0d] got=%b want=0", j, bus.active); end
      total++; if (bus.center !== 1'b0) begin bad++; $display("FAIL stop_hold_center[%0d] got=%b want=0", j, bus.center); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'd2, 4'd4);
    repeat (12) tick();
    total++; if (bus.pos !== -8'sd12) begin bad++; $display("FAIL rmid_start got=%0d want=-12", $signed(bus.pos)); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.pos !== 8'sd0) begin bad++; $display("FAIL rmid_pos got=%0d want=0", $signed(bus.pos)); end
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL rmid_pwm got=%b want=0", bus.pwm_out); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL rmid_active got=%b want=0", bus.active); end
    total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL rmid_dir got=%b want=1", bus.dir); end
    bus.A = 4'd1;
    bus.F = 4'd1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.pos !== 8'(i)) begin bad++; $display("FAIL rmid_restart_pos[%0d] got=%0d want=%0d", i, $signed(bus.pos), i); end
      total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL rmid_restart_active[%0d] got=%b want=1", i, bus.active); end
      total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL rmid_restart_dir[%0d] got=%b want=1", i, bus.dir); end
    end
  endtask

  task automatic test_pwm_duty();
    int hi;
    int n;
    int target;
    int want;
    @(negedge clk);
    bus_p.A = 4'd0;
    bus_p.F = 4'd0;
    reset_p = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      target = (k == 0) ? 0 : ((k == 1) ? 16 : -120);
      want   = (k == 0) ? 128 : ((k == 1) ? 144 : 8);
      if (k == 1) begin bus_p.A = 4'd2; bus_p.F = 4'd4; end
      if (k == 2) begin bus_p.A = 4'd15; bus_p.F = 4'd15; end
      n = 0;
      while ((bus_p.pos !== 8'(target)) && (n < 40000)) begin
        @(negedge clk);
        n++;
      end
      total++; if (n >= 40000) begin bad++; $display("FAIL pwm_reach[%0d] got=%0d want=%0d", k, $signed(bus_p.pos), target); end
      repeat (2) @(negedge clk);
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        if (bus_p.pwm_out === 1'b1) hi++;
      end
      total++; if (hi != want) begin bad++; $display("FAIL pwm_duty[%0d] got=%0d want=%0d", k, hi, want); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    reset_p = 1'b1;
    bus.A   = 4'd0;
    bus.F   = 4'd0;
    bus_p.A = 4'd0;
    bus_p.F = 4'd0;
    test_reset();
    test_basic_swing();
    test_deferred_update();
    test_clamp();
    test_stop();
    test_reset_mid();
    test_pwm_duty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rock_generator.md
Name: rock_generator

Overview:
Downstream stage of the rocking controller. Consumes the 4-bit amplitude (A) and frequency (F) codes from the controller and produces a symmetric triangle swing position for the cradle actuator. It also produces a PWM drive signal for that position. New A/F values are taken over only when the swing passes through centre, so amplitude or speed changes never jerk the cradle.

Parameters:
TICK_DIV, 50000, clock cycles per motion tick (1 kHz at 50 MHz); must be >= 2
PEAK_SCALE, 8, position units per amplitude step (peak = A_l * PEAK_SCALE; A=15 gives 120)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
A  in  4  requested amplitude code from controller (0 = stop)
F  in  4  requested frequency code; position units moved per tick (0 = stop)
pos  out  8  signed swing position, two's complement, range -120..+120
dir  out  1  1 = moving toward +peak, 0 = toward -peak
center  out  1  one-clock pulse on the tick the swing reaches or crosses 0
active  out  1  1 while swinging (state SWING_UP or SWING_DOWN)
pwm_out  out  1  actuator PWM; duty = (pos+128)/256

Behaviour:
- Clocking and reset
  - Single clock.
  - Reset is synchronous and active-high.
  - On reset: pos=0, dir=1, center=0, active=0, pwm_out=0, prescaler=0, PWM counter=0, A_l=0, F_l=0, state IDLE.
  - Reset mid-swing takes effect at the next edge; no return-to-centre motion is performed.
- Prescaler: counts 0..TICK_DIV-1; tick is asserted for one clock when the count equals TICK_DIV-1. Everything below, except PWM, updates only on tick.
- Latched values: A_l and F_l are internal copies of A and F. peak = A_l*PEAK_SCALE.
- IDLE
  - Each tick: latch A_l<=A, F_l<=F.
  - If both latched values are nonzero: state<=SWING_UP, dir=1.
  - pos stays 0. The first movement occurs on the following tick.
- SWING_UP / SWING_DOWN, each tick
  - Compute nxt = pos + F_l (UP) or pos - F_l (DOWN), in 9-bit signed arithmetic.
  - Centre event: pos != 0 and (nxt == 0 or sign(nxt) != sign(pos)).
  - On a centre event:
    - center=1 for this clock.
    - A_l<=A, F_l<=F.
    - If the new A or new F is 0: pos<=0, state IDLE, active=0, dir=1.
    - Otherwise the new peak applies in the clamp below, in the same tick.
  - Clamp (against the current peak):
    - UP and nxt >= peak: pos<=peak, state SWING_DOWN, dir=0.
    - DOWN and nxt <= -peak: pos<=-peak, state SWING_UP, dir=1.
    - Otherwise pos<=nxt.
  - A/F changes between centre events are ignored.
- center and tick timing: center is 0 on all non-tick clocks; at most one center pulse per tick.
- PWM
  - 8-bit free-running counter, incremented every clock.
  - pwm_out is registered: pwm_out <= (counter < pos+128), using an unsigned 8-bit compare.
  - pos=-120 gives duty 8/256; pos=+120 gives duty 248/256.
- Boundaries
  - F_l > |peak| is legal; the clamp keeps pos within ±peak.
  - A tick landing exactly on peak reverses direction in that tick.
  - pos never exceeds ±120.

Test Plan (TICK_DIV=2 unless noted):
- Basic swing: reset; A=2, F=4 → IDLE one tick, then pos 4,8,12,16 (dir->0), 12,8,4,0 (center pulse, active=1), -4,…,-16 (dir->1), -12, …; period 16 ticks.
- Deferred update: A=2, F=4 swinging down at pos=12; set A=1 → pos 8,4,0 with the old peak; after centre the peak is 8: pos -4,-8, reversal at -8.
- Clamp/overshoot: A=1, F=15 from IDLE → pos 8 (clamped, dir=0); next tick 8-15=-7 gives a center pulse, pos=-7; next tick pos=-8 clamped, dir=1.
- Stop request: swinging A=3, F=2 at pos=+14 up; set F=0 → continues to +24, returns; at the tick reaching 0: center=1, pos=0, active=0, state IDLE; stays 0 thereafter.
- Reset mid-operation: assert reset at pos=-12 → next clock pos=0, pwm_out=0, active=0; release with A=1, F=1 → swing restarts from 0 upward.
- PWM duty (TICK_DIV=1000): hold pos=0 → 128 high clocks per 256; pos=+16 → 144/256; pos=-120 → 8/256.
